// File: rtl/uncache_agent.sv
// Uncached data-port agent: turns one SRAM-like core access into a single
// AXI4-Lite-style read or write beat and stalls the core until it completes.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_en/we/addr/wdata : core access (we == 0 means read)
//   req_rdata         : last completed read data, held across writes
//   stallreq_uncache  : high while an access is pending
//   bus_err           : response error, valid only in the completion cycle
//   ar*/r*/aw*/w*/b*  : single-beat bus channels
module uncache_agent #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_en,
    input  logic [DATA_WD/8-1:0] req_we,
    input  logic [ADDR_WD-1:0]   req_addr,
    input  logic [DATA_WD-1:0]   req_wdata,
    output logic [DATA_WD-1:0]   req_rdata,
    output logic                 stallreq_uncache,
    output logic                 bus_err,
    output logic [ADDR_WD-1:0]   araddr,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [DATA_WD-1:0]   rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ADDR_WD-1:0]   awaddr,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_WD-1:0]   wdata,
    output logic [DATA_WD/8-1:0] wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_REQ = 3'd3,
        WR_B   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WD-1:0]   addr_q;
    logic [DATA_WD-1:0]   wdata_q;
    logic [DATA_WD/8-1:0] wstrb_q;
    logic [DATA_WD-1:0]   rdata_q;
    logic                 err_q;
    logic                 aw_pend_q;
    logic                 w_pend_q;

    logic start;
    logic aw_left;
    logic w_left;

    assign start = (state_q == IDLE) && req_en;

    // A channel is still outstanding after this cycle unless it handshakes now.
    assign aw_left = aw_pend_q && !awready;
    assign w_left  = w_pend_q && !wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_en) begin
                    state_d = (req_we != '0) ? WR_REQ : RD_AR;
                end
            end
            RD_AR:   if (arready) state_d = RD_R;
            RD_R:    if (rvalid) state_d = DONE;
            WR_REQ:  if (!aw_left && !w_left) state_d = WR_B;
            WR_B:    if (bvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arvalid          = 1'b0;
        rready           = 1'b0;
        awvalid          = 1'b0;
        wvalid           = 1'b0;
        bready           = 1'b0;
        bus_err          = 1'b0;
        stallreq_uncache = start;
        unique case (state_q)
            IDLE: ;
            RD_AR: begin
                arvalid          = 1'b1;
                stallreq_uncache = 1'b1;
            end
            RD_R: begin
                rready           = 1'b1;
                stallreq_uncache = 1'b1;
            end
            WR_REQ: begin
                awvalid          = aw_pend_q;
                wvalid           = w_pend_q;
                stallreq_uncache = 1'b1;
            end
            WR_B: begin
                bready           = 1'b1;
                stallreq_uncache = 1'b1;
            end
            DONE: begin
                bus_err = err_q;
            end
            default: ;
        endcase
    end

    // Request latch, per-channel pending flags, read data and error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            if (start) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_we;
                err_q     <= 1'b0;
                aw_pend_q <= (req_we != '0);
                w_pend_q  <= (req_we != '0);
            end
            if (state_q == WR_REQ) begin
                aw_pend_q <= aw_left;
                w_pend_q  <= w_left;
            end
            if (state_q == RD_R && rvalid) begin
                rdata_q <= rdata;
                err_q   <= (rresp != 2'b00);
            end
            if (state_q == WR_B && bvalid) begin
                err_q <= (bresp != 2'b00);
            end
        end
    end

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_uncache_agent.sv
// Bench for uncache_agent: directed and random single accesses, checked
// against a cycle schedule derived from the responder's wait counts.
module tb_uncache_agent;

    logic        clk;
    logic        reset;
    logic        req_en;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rdata;
    logic        stallreq_uncache;
    logic        bus_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    uncache_agent dut (
        .clk              (clk),
        .reset            (reset),
        .req_en           (req_en),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rdata        (req_rdata),
        .stallreq_uncache (stallreq_uncache),
        .bus_err          (bus_err),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .awaddr           (awaddr),
        .awvalid          (awvalid),
        .awready          (awready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wvalid           (wvalid),
        .wready           (wready),
        .bresp            (bresp),
        .bvalid           (bvalid),
        .bready           (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          ar_cnt = 0;
    int          aw_cnt = 0;
    int          w_cnt  = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        req_en    = 1'b0;
        req_we    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = $urandom;
        rresp     = 2'b00;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
    endtask

    // One access. da/dw: cycles the AW(or AR)/W ready stays low after the
    // request; db: cycles the response waits after the last address/data
    // handshake. hold re-presents the request in the completion cycle.
    task automatic run_access(input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wd, input int da,
                              input int dw, input int db,
                              input logic [1:0] resp, input logic [31:0] rd,
                              input bit hold);
        bit is_wr;
        int ahs, whs, last, rhs, done;
        int a0, w0;
        is_wr = (we != 4'b0);
        ahs   = 1 + da;
        whs   = is_wr ? 1 + dw : ahs;
        last  = (ahs > whs) ? ahs : whs;
        rhs   = last + 1 + db;
        done  = rhs + 1;
        a0    = aw_cnt;
        w0    = w_cnt;
        for (int c = 0; c <= done; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 0 || (hold && c == done)) begin
                req_en    = 1'b1;
                req_we    = we;
                req_addr  = addr;
                req_wdata = wd;
            end
            if (is_wr) begin
                awready = (c >= ahs);
                wready  = (c >= whs);
                bvalid  = (c >= rhs);
                bresp   = (c >= rhs) ? resp : 2'b00;
            end else begin
                arready = (c >= ahs);
                rvalid  = (c >= rhs);
                if (c >= rhs) begin
                    rdata = rd;
                    rresp = resp;
                end
            end
            #1;
            if (arvalid && arready) ar_cnt++;
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
            chk("stall", 32'(stallreq_uncache), 32'(c < done));
            chk("arvalid", 32'(arvalid),
                32'(!is_wr && c >= 1 && c <= ahs));
            chk("rready", 32'(rready),
                32'(!is_wr && c > ahs && c <= rhs));
            chk("awvalid", 32'(awvalid),
                32'(is_wr && c >= 1 && c <= ahs));
            chk("wvalid", 32'(wvalid),
                32'(is_wr && c >= 1 && c <= whs));
            chk("bready", 32'(bready),
                32'(is_wr && c > last && c <= rhs));
            chk("bus_err", 32'(bus_err),
                32'(c == done && resp != 2'b00));
            chk("req_rdata", req_rdata,
                (c == done && !is_wr) ? rd : model_rdata);
            if (!is_wr && c >= 1 && c <= ahs) chk("araddr", araddr, addr);
            if (is_wr && c >= 1 && c <= ahs) chk("awaddr", awaddr, addr);
            if (is_wr && c >= 1 && c <= whs) begin
                chk("wdata", wdata, wd);
                chk("wstrb", 32'(wstrb), 32'(we));
            end
        end
        if (!is_wr) model_rdata = rd;
        if (is_wr) begin
            chk("aw_beats", 32'(aw_cnt - a0), 32'd1);
            chk("w_beats", 32'(w_cnt - w0), 32'd1);
        end
    endtask

    initial begin
        int ar0;
        logic [3:0]  rwe;
        logic [1:0]  rsp;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stallreq_uncache), 32'd0);
        chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}),
            32'd0);
        chk("rst_rdata", req_rdata, 32'h0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Read with AR wait of 2 and R three cycles after the AR handshake.
        ar0 = ar_cnt;
        run_access(4'b0000, 32'hBFAF_8000, 32'h0, 2, 0, 2, 2'b00,
                   32'h1234_5678, 1'b0);
        chk("read_ar_once", 32'(ar_cnt - ar0), 32'd1);

        // Write with AW at +1, W at +3, B at +5.
        run_access(4'b0001, 32'hBFAF_F020, 32'h0000_00A5, 0, 2, 1, 2'b00,
                   32'h0, 1'b0);

        // Zero-wait read: AR at C+1, R at C+2, completion at C+3.
        run_access(4'b0000, 32'hBFAF_8004, 32'h0, 0, 0, 0, 2'b00,
                   32'hCAFE_F00D, 1'b0);

        // Back-to-back reads, request still asserted in the completion cycle.
        ar0 = ar_cnt;
        run_access(4'b0000, 32'h1000_0010, 32'h0, 0, 0, 1, 2'b00,
                   32'hAAAA_5555, 1'b1);
        run_access(4'b0000, 32'h1000_0014, 32'h0, 1, 0, 0, 2'b00,
                   32'h0F0F_F0F0, 1'b0);
        chk("b2b_ar_count", 32'(ar_cnt - ar0), 32'd2);

        // Error responses.
        run_access(4'b1111, 32'h2000_0000, 32'hDEAD_BEEF, 1, 1, 0, 2'b10,
                   32'h0, 1'b0);
        run_access(4'b0000, 32'h2000_0004, 32'h0, 0, 0, 1, 2'b11,
                   32'h7777_0001, 1'b0);

        // Reset while waiting in the R phase.
        @(negedge clk);
        idle_inputs();
        req_en   = 1'b1;
        req_we   = 4'b0000;
        req_addr = 32'h3000_0000;
        @(negedge clk);
        idle_inputs();
        arready = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_rst_rready", 32'(rready), 32'd1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        model_rdata = 32'h0;
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_rready", 32'(rready), 32'd0);
        chk("midrst_stall", 32'(stallreq_uncache), 32'd0);
        chk("midrst_rdata", req_rdata, 32'h0);
        run_access(4'b0000, 32'h3000_0008, 32'h0, 0, 0, 2, 2'b00,
                   32'h4242_4242, 1'b0);

        // Random accesses.
        for (int i = 0; i < 40; i++) begin
            rwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15))
                                              : 4'b0000;
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3))
                                              : 2'b00;
            run_access(rwe, $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), rsp,
                       $urandom, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
